// File: rtl/traffic_ctrl.sv
// traffic_ctrl: timed light-phase sequencer with latched pedestrian walk phase.
// Define TRAFFIC_BLINK_EN to blink yellow/off while disabled.
module traffic_ctrl #(
  parameter int C_CLK_FRQ   = 100000000,
  parameter int C_GREEN_MS  = 5000,
  parameter int C_YELLOW_MS = 2000,
  parameter int C_RED_MS    = 4000,
  parameter int C_WALK_MS   = 3000,
  parameter int C_BLINK_MS  = 500
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       inEn,
  input  logic       inWalkReq,
  output logic [2:0] outSel,
  output logic       outWalkPend,
  output logic       outWalkAck
);
  localparam int P = C_CLK_FRQ / 1000;
  localparam int PW = P > 1 ? $clog2(P) : 1;
  localparam int M1 = C_GREEN_MS > C_YELLOW_MS ? C_GREEN_MS : C_YELLOW_MS;
  localparam int M2 = C_RED_MS > C_WALK_MS ? C_RED_MS : C_WALK_MS;
  localparam int M3 = M1 > M2 ? M1 : M2;
  localparam int MAXD = M3 > C_BLINK_MS ? M3 : C_BLINK_MS;
  localparam int MW = $clog2(MAXD + 1);
  typedef enum logic [2:0] {
    S_RED    = 3'b000,
    S_GREEN  = 3'b001,
    S_YELLOW = 3'b010,
    S_WALK   = 3'b011,
    S_OFF    = 3'b100
  } state_t;
  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [MW-1:0]   ms_q, ms_d, dur;
  logic [2:0]      sel_q, sel_d;
  logic            pend_q, pend_d, ack_q, ack_d;
  logic            tick, done, clr, enter_walk;
`ifdef TRAFFIC_BLINK_EN
  logic            blink_q, blink_d;
`endif
  always_comb begin
    dur = state_q == S_RED    ? MW'(C_RED_MS) :
          state_q == S_GREEN  ? MW'(C_GREEN_MS) :
          state_q == S_YELLOW ? MW'(C_YELLOW_MS) :
          state_q == S_WALK   ? MW'(C_WALK_MS) : MW'(C_BLINK_MS);
    tick = pre_q == PW'(P - 1);
    done = tick && (ms_q + MW'(1) == dur);
    state_d = !inEn ? S_OFF :
              state_q == S_OFF ? S_RED :
              !done ? state_q :
              state_q == S_RED ? S_GREEN :
              state_q == S_GREEN ? S_YELLOW :
              state_q == S_YELLOW ? (pend_q ? S_WALK : S_RED) : S_RED;
    enter_walk = state_d == S_WALK && state_q != S_WALK;
    pend_d = (!inEn || enter_walk) ? 1'b0 : pend_q | (inWalkReq && state_q != S_WALK);
    ack_d = enter_walk;
`ifdef TRAFFIC_BLINK_EN
    // counters keep running in OFF to time the blink
    clr = state_d != state_q;
    blink_d = state_d != S_OFF ? 1'b0 : (state_q == S_OFF && done) ? ~blink_q : blink_q;
    sel_d = (state_d == S_OFF && blink_d) ? S_YELLOW : state_d;
`else
    clr = state_d != state_q || state_q == S_OFF;
    sel_d = state_d;
`endif
    pre_d = (clr || tick) ? '0 : pre_q + PW'(1);
    ms_d = (clr || done) ? '0 : ms_q + MW'(tick);
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_OFF;
      sel_q   <= S_OFF;
      pre_q   <= '0;
      ms_q    <= '0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
`ifdef TRAFFIC_BLINK_EN
      blink_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
`ifdef TRAFFIC_BLINK_EN
      blink_q <= blink_d;
`endif
    end
  end
  assign outSel      = sel_q;
  assign outWalkPend = pend_q;
  assign outWalkAck  = ack_q;
endmodule

// File: tb/tb_traffic_ctrl.sv
// tb_traffic_ctrl: directed checks of phase timing, walk latch, disable and reset.
module tb_traffic_ctrl;
  logic       clk, rstb, inEn, inWalkReq;
  logic [2:0] outSel;
  logic       outWalkPend, outWalkAck;
  int vecs = 0;
  int errs = 0;

  traffic_ctrl #(
    .C_CLK_FRQ(1000), .C_GREEN_MS(5), .C_YELLOW_MS(2),
    .C_RED_MS(4), .C_WALK_MS(3), .C_BLINK_MS(2)
  ) dut (
    .clk(clk), .rstb(rstb), .inEn(inEn), .inWalkReq(inWalkReq),
    .outSel(outSel), .outWalkPend(outWalkPend), .outWalkAck(outWalkAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // leaves time just after a rising edge, reset released; next edge starts cycle 1
  task automatic do_reset(input logic en);
    rstb = 1'b0;
    inEn = en;
    inWalkReq = 1'b0;
    @(posedge clk);
    #1;
    rstb = 1'b1;
  endtask

  task automatic test_reset;
    logic [2:0] exp;
    rstb = 1'b0;
    inEn = 1'b1;
    inWalkReq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (outSel !== 3'b100) begin errs++; $display("FAIL reset_sel got %b want 100", outSel); end
    vecs++; if (outWalkPend !== 1'b0) begin errs++; $display("FAIL reset_pend got %b want 0", outWalkPend); end
    vecs++; if (outWalkAck !== 1'b0) begin errs++; $display("FAIL reset_ack got %b want 0", outWalkAck); end
    rstb = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      exp = c <= 4 ? 3'b000 : c <= 9 ? 3'b001 : c <= 11 ? 3'b010 : c <= 15 ? 3'b000 : 3'b001;
      vecs++; if (outSel !== exp) begin errs++; $display("FAIL cycle_sel c=%0d got %b want %b", c, outSel, exp); end
      vecs++; if (outWalkAck !== 1'b0) begin errs++; $display("FAIL cycle_ack c=%0d got %b want 0", c, outWalkAck); end
    end
  endtask

  task automatic test_walk_pulse;
    logic [2:0] exp;
    do_reset(1'b1);
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk);
      #1;
      exp = c <= 4 ? 3'b000 : c <= 9 ? 3'b001 : c <= 11 ? 3'b010 : c <= 14 ? 3'b011 : c <= 18 ? 3'b000 : 3'b001;
      vecs++; if (outSel !== exp) begin errs++; $display("FAIL walk_sel c=%0d got %b want %b", c, outSel, exp); end
      vecs++; if (outWalkPend !== (c >= 7 && c <= 11)) begin errs++; $display("FAIL walk_pend c=%0d got %b want %b", c, outWalkPend, (c >= 7 && c <= 11)); end
      vecs++; if (outWalkAck !== (c == 12)) begin errs++; $display("FAIL walk_ack c=%0d got %b want %b", c, outWalkAck, (c == 12)); end
      inWalkReq = (c == 6);
    end
    inWalkReq = 1'b0;
  endtask

  task automatic test_walk_held;
    logic [2:0] exp;
    logic ep;
    do_reset(1'b1);
    inWalkReq = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      exp = c <= 4 ? 3'b000 : c <= 9 ? 3'b001 : c <= 11 ? 3'b010 : c <= 14 ? 3'b011 :
            c <= 18 ? 3'b000 : c <= 23 ? 3'b001 : c <= 25 ? 3'b010 : c <= 28 ? 3'b011 : 3'b000;
      vecs++; if (outSel !== exp) begin errs++; $display("FAIL held_sel c=%0d got %b want %b", c, outSel, exp); end
      vecs++; if (outWalkAck !== (c == 12 || c == 26)) begin errs++; $display("FAIL held_ack c=%0d got %b want %b", c, outWalkAck, (c == 12 || c == 26)); end
      if (c != 15 && c != 29) begin
        ep = !((c >= 12 && c <= 14) || (c >= 26 && c <= 28));
        vecs++; if (outWalkPend !== ep) begin errs++; $display("FAIL held_pend c=%0d got %b want %b", c, outWalkPend, ep); end
      end
    end
    inWalkReq = 1'b0;
  endtask

  task automatic test_disable;
    logic [2:0] exp;
    do_reset(1'b1);
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk);
      #1;
      exp = c <= 4 ? 3'b000 : c <= 6 ? 3'b001 : c <= 8 ? 3'b100 : c <= 12 ? 3'b000 : 3'b001;
      vecs++; if (outSel !== exp) begin errs++; $display("FAIL dis_sel c=%0d got %b want %b", c, outSel, exp); end
      if (c == 6) begin
        vecs++; if (outWalkPend !== 1'b1) begin errs++; $display("FAIL dis_pend_set got %b want 1", outWalkPend); end
      end
      if (c == 7 || c == 8) begin
        vecs++; if (outWalkPend !== 1'b0) begin errs++; $display("FAIL dis_pend_clr c=%0d got %b want 0", c, outWalkPend); end
      end
      inWalkReq = (c == 5);
      inEn = !(c == 6 || c == 7);
    end
  endtask

  task automatic test_async_reset;
    logic [2:0] exp;
    do_reset(1'b1);
    repeat (10) @(posedge clk);
    #1;
    vecs++; if (outSel !== 3'b010) begin errs++; $display("FAIL async_pre got %b want 010", outSel); end
    #2;
    rstb = 1'b0;
    #1;
    vecs++; if (outSel !== 3'b100) begin errs++; $display("FAIL async_sel got %b want 100", outSel); end
    vecs++; if (outWalkPend !== 1'b0) begin errs++; $display("FAIL async_pend got %b want 0", outWalkPend); end
    @(posedge clk);
    #1;
    rstb = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      exp = c <= 4 ? 3'b000 : 3'b001;
      vecs++; if (outSel !== exp) begin errs++; $display("FAIL async_seq c=%0d got %b want %b", c, outSel, exp); end
    end
  endtask

  task automatic test_off_state;
    logic [2:0] exp;
    do_reset(1'b0);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
`ifdef TRAFFIC_BLINK_EN
      exp = ((c / 2) % 2) != 0 ? 3'b010 : 3'b100;
`else
      exp = 3'b100;
`endif
      vecs++; if (outSel !== exp) begin errs++; $display("FAIL off_sel c=%0d got %b want %b", c, outSel, exp); end
    end
  endtask

  initial begin
    rstb = 1'b0;
    inEn = 1'b0;
    inWalkReq = 1'b0;
    test_reset;
    test_walk_pulse;
    test_walk_held;
    test_disable;
    test_async_reset;
    test_off_state;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/traffic_ctrl.md
# traffic_ctrl

Phase sequencer for the traffic-light demo: a timed state machine that produces the 3-bit light selection code consumed by the RGB LED light driver. It latches pedestrian requests, inserts a red-and-walk phase when one is pending, and parks the lights in an off (or blinking) state when disabled. It sits between the debounced board inputs (enable switch, walk button) and the light driver's selection input.

## Interface

- C_CLK_FRQ, 100000000, clock frequency in Hz; must be a multiple of 1000 and ≥ 1000.
- C_GREEN_MS, 5000, green phase duration in ms; must be ≥ 1.
- C_YELLOW_MS, 2000, yellow phase duration in ms; must be ≥ 1.
- C_RED_MS, 4000, red phase duration in ms; must be ≥ 1.
- C_WALK_MS, 3000, red-and-walk phase duration in ms; must be ≥ 1.
- C_BLINK_MS, 500, half-period of off-state blinking in ms; must be ≥ 1; used only with TRAFFIC_BLINK_EN.

Ports:
- clk  input  1  master clock.
- rstb  input  1  reset, asynchronous, active-low.
- inEn  input  1  run enable, debounced level; low forces the OFF state.
- inWalkReq  input  1  pedestrian request, debounced level; sampled every cycle.
- outSel  output  3  light selection code: 000 red, 001 green, 010 yellow, 011 red+walk, 100 off.
- outWalkPend  output  1  pedestrian request latched and not yet served.
- outWalkAck  output  1  one-cycle pulse on entry to WALK.

## Operation

- States and codes: OFF (100), RED (000), GREEN (001), YELLOW (010), WALK (011). outSel is a register always equal to the current state's code.
- Reset: state OFF, outSel = 100, outWalkPend = 0, outWalkAck = 0, all counters 0.
- Transitions, evaluated only while inEn = 1:
  - OFF → RED on the first cycle with inEn = 1.
  - RED → GREEN at the end of RED.
  - GREEN → YELLOW at the end of GREEN.
  - YELLOW → WALK at the end of YELLOW if the latch is set; otherwise YELLOW → RED.
  - WALK → RED at the end of WALK.
- inEn = 0 in any state: next state is OFF, the walk latch clears, and the timers clear.
- Walk latch:
  - Sets on any cycle with inWalkReq = 1 and inEn = 1, except while in WALK.
  - Clears on the cycle WALK is entered.
  - When a set and an entry-clear occur on the same edge, the clear wins; a request held through WALK re-latches on the first RED cycle.
- outWalkPend equals the latch. outWalkAck is high for exactly the first cycle in WALK.
- Timer:
  - A prescaler counts 0 .. C_CLK_FRQ/1000−1 and emits a 1 ms tick on its terminal count.
  - A ms counter counts ticks within the phase; width is sized for the largest duration parameter.
  - Both counters reset to 0 on every state change.
  - A phase ends on the tick that brings the ms counter to its duration D.

## Timing

- Each timed phase lasts exactly D × C_CLK_FRQ/1000 clock cycles, measured from the first cycle outSel shows the code to the last.
- Full cycle without walk: RED + GREEN + YELLOW. With walk: + WALK.
- OFF → RED takes one cycle after inEn is sampled high. Any state → OFF takes one cycle after inEn is sampled low.
- Asynchronous reset mid-phase returns immediately to the reset values, with no partial phase resumed.
- inEn and inWalkReq are assumed synchronous to clk; no internal synchronizers.

## Configuration

- TRAFFIC_BLINK_EN defined:
  - In OFF, outSel alternates 010 and 100 every C_BLINK_MS, starting with 100 on entry, using the same prescaler/ms counter.
  - Leaving OFF drops the blink immediately.
- TRAFFIC_BLINK_EN undefined:
  - OFF holds 100 constantly and the blink logic is absent.
- All other behaviour is identical in both builds.

## Test plan

All scenarios use C_CLK_FRQ=1000 (1 cycle per ms), GREEN=5, YELLOW=2, RED=4, WALK=3, BLINK=2.

- Reset held, then released with inEn=1 → outSel=100 during reset, 000 one cycle later for 4 cycles, then 001 ×5, 010 ×2, 000 ×4, repeating; outWalkAck never pulses.
- inWalkReq pulsed for 1 cycle during GREEN → outWalkPend=1 from the next cycle; after YELLOW, outSel=011 for 3 cycles with outWalkAck high on the first; outWalkPend=0 from WALK entry; then 000 ×4.
- inWalkReq held high continuously → WALK inserted every cycle; outWalkPend re-asserts on the first RED cycle after each WALK.
- inEn dropped mid-GREEN (cycle 2) → outSel=100 the next cycle and outWalkPend=0; inEn re-raised → 000 for a full 4 cycles.
- rstb asserted mid-YELLOW → outSel=100 asynchronously without waiting for a clock edge; after release, the sequence restarts from RED with a full duration.
- With TRAFFIC_BLINK_EN and inEn=0 → outSel sequence 100,100,010,010,100,… ; without the macro → constant 100.
